// File: rtl/phy_tx_lane_sched.sv
// Byte-rate transmit scheduler: COM training on link enable, then round-robin
// sharing of one serializer path between four lanes with a per-grant burst cap.
module phy_tx_lane_sched #(
    parameter logic [7:0]  COM_BYTE  = 8'hBC,
    parameter logic [7:0]  IDLE_BYTE = 8'h7C,
    parameter int unsigned TRAIN_LEN = 4,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic       clk4f,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] req,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    input  logic [7:0] data2,
    input  logic [7:0] data3,
    input  logic [3:0] last,
    output logic [3:0] ack,
    output logic [7:0] out_byte,
    output logic       out_valid,
    output logic       active,
    output logic [1:0] cur_owner
);

    localparam logic [1:0] S_RESET = 2'd0;
    localparam logic [1:0] S_TRAIN = 2'd1;
    localparam logic [1:0] S_IDLE  = 2'd2;
    localparam logic [1:0] S_GRANT = 2'd3;

    logic [1:0] state_q, state_d;
    logic [3:0] train_cnt_q, train_cnt_d;
    logic [3:0] burst_cnt_q, burst_cnt_d;
    logic [1:0] rr_ptr_q, rr_ptr_d;
    logic [1:0] owner_q, owner_d;
    logic [7:0] out_byte_q, out_byte_d;
    logic       out_valid_q, out_valid_d;
    logic       active_q, active_d;
    logic [1:0] cur_owner_q, cur_owner_d;

    logic [7:0] lane_data [4];
    logic [7:0] owner_data;
    logic       owner_req;
    logic       found;
    logic [1:0] winner;

    assign lane_data[0] = data0;
    assign lane_data[1] = data1;
    assign lane_data[2] = data2;
    assign lane_data[3] = data3;
    assign owner_data   = lane_data[owner_q];
    assign owner_req    = req[owner_q];

    assign ack = (!reset && enable && state_q == S_GRANT && owner_req) ?
                 (4'b0001 << owner_q) : 4'b0000;

    // First requester found scanning upward from rr_ptr, wrapping mod 4.
    always_comb begin
        found  = 1'b0;
        winner = rr_ptr_q;
        for (int i = 0; i < 4; i++) begin
            if (!found && req[rr_ptr_q + 2'(i)]) begin
                found  = 1'b1;
                winner = rr_ptr_q + 2'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        train_cnt_d = train_cnt_q;
        burst_cnt_d = burst_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        out_byte_d  = out_byte_q;
        out_valid_d = out_valid_q;
        active_d    = active_q;
        cur_owner_d = cur_owner_q;
        if (!enable) begin
            state_d     = S_RESET;
            out_byte_d  = 8'h00;
            out_valid_d = 1'b0;
            active_d    = 1'b0;
            burst_cnt_d = 4'd0;
        end else begin
            case (state_q)
                S_RESET: begin
                    state_d     = S_TRAIN;
                    train_cnt_d = 4'd0;
                    out_byte_d  = 8'h00;
                    out_valid_d = 1'b0;
                    active_d    = 1'b0;
                end
                S_TRAIN: begin
                    out_byte_d  = COM_BYTE;
                    out_valid_d = 1'b1;
                    train_cnt_d = train_cnt_q + 4'd1;
                    if (train_cnt_q == 4'(TRAIN_LEN - 1)) begin
                        state_d = S_IDLE;
                    end
                end
                S_IDLE: begin
                    out_byte_d  = IDLE_BYTE;
                    out_valid_d = 1'b1;
                    active_d    = 1'b1;
                    if (found) begin
                        owner_d     = winner;
                        cur_owner_d = winner;
                        burst_cnt_d = 4'd0;
                        state_d     = S_GRANT;
                    end
                end
                default: begin
                    out_valid_d = 1'b1;
                    if (owner_req) begin
                        out_byte_d  = owner_data;
                        burst_cnt_d = burst_cnt_q + 4'd1;
                        // last and the burst cap coinciding still end just one burst
                        if (last[owner_q] || burst_cnt_q == 4'(MAX_BURST - 1)) begin
                            state_d  = S_IDLE;
                            rr_ptr_d = owner_q + 2'd1;
                        end
                    end else begin
                        out_byte_d = IDLE_BYTE;
                        state_d    = S_IDLE;
                        rr_ptr_d   = owner_q + 2'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk4f) begin
        if (reset) begin
            state_q     <= S_RESET;
            train_cnt_q <= 4'd0;
            burst_cnt_q <= 4'd0;
            rr_ptr_q    <= 2'd0;
            owner_q     <= 2'd0;
            out_byte_q  <= 8'h00;
            out_valid_q <= 1'b0;
            active_q    <= 1'b0;
            cur_owner_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            train_cnt_q <= train_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            out_byte_q  <= out_byte_d;
            out_valid_q <= out_valid_d;
            active_q    <= active_d;
            cur_owner_q <= cur_owner_d;
        end
    end

    assign out_byte  = out_byte_q;
    assign out_valid = out_valid_q;
    assign active    = active_q;
    assign cur_owner = cur_owner_q;

endmodule

// File: tb/tb_phy_tx_lane_sched.sv
// Scoreboard bench for phy_tx_lane_sched: the driver queues the expected ack for
// each cycle and the outputs registered at its closing edge; a monitor pops and compares.
module tb_phy_tx_lane_sched;

    logic       clk4f = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] req;
    logic [7:0] data0, data1, data2, data3;
    logic [3:0] last;
    logic [3:0] ack;
    logic [7:0] out_byte;
    logic       out_valid;
    logic       active;
    logic [1:0] cur_owner;

    typedef struct packed {
        logic [3:0] ack;
        logic [7:0] byt;
        logic       vld;
        logic       act;
        logic       chk_own;
        logic [1:0] own;
    } exp_t;

    exp_t       sb_q [$];
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    logic [3:0] ack_s;
    logic [7:0] lane_b [4];

    always #5 clk4f = ~clk4f;

    phy_tx_lane_sched dut (
        .clk4f     (clk4f),
        .reset     (reset),
        .enable    (enable),
        .req       (req),
        .data0     (data0),
        .data1     (data1),
        .data2     (data2),
        .data3     (data3),
        .last      (last),
        .ack       (ack),
        .out_byte  (out_byte),
        .out_valid (out_valid),
        .active    (active),
        .cur_owner (cur_owner)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, expv);
        end
    endtask

    task automatic step(input logic en, input logic [3:0] rq, input logic [3:0] lst,
                        input logic [3:0] e_ack, input logic [7:0] e_byte,
                        input logic e_vld, input logic e_act,
                        input logic c_own, input logic [1:0] e_own);
        exp_t e;
        enable    = en;
        req       = rq;
        last      = lst;
        e.ack     = e_ack;
        e.byt     = e_byte;
        e.vld     = e_vld;
        e.act     = e_act;
        e.chk_own = c_own;
        e.own     = e_own;
        sb_q.push_back(e);
        @(negedge clk4f);
    endtask

    // Monitor: ack sampled mid-cycle, registered outputs just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk4f);
            #1 ack_s = ack;
            @(posedge clk4f);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("ack", 32'(ack_s), 32'(e.ack));
                chk("out_byte", 32'(out_byte), 32'(e.byt));
                chk("out_valid", 32'(out_valid), 32'(e.vld));
                chk("active", 32'(active), 32'(e.act));
                if (e.chk_own) chk("cur_owner", 32'(cur_owner), 32'(e.own));
                cyc++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        lane_b[0] = 8'hA0;
        lane_b[1] = 8'hB1;
        lane_b[2] = 8'hC2;
        lane_b[3] = 8'hD3;
        reset  = 1'b1;
        enable = 1'b0;
        req    = 4'b0;
        last   = 4'b0;
        data0  = lane_b[0];
        data1  = lane_b[1];
        data2  = lane_b[2];
        data3  = lane_b[3];
        @(negedge clk4f);

        // Reset state
        step(0, 4'b0, 4'b0, 4'b0, 8'h00, 0, 0, 1, 2'd0);
        step(0, 4'b0, 4'b0, 4'b0, 8'h00, 0, 0, 1, 2'd0);
        reset = 1'b0;

        // Enable: one edge leaving reset, four COM bytes, then IDLE with active
        step(1, 4'b0, 4'b0, 4'b0, 8'h00, 0, 0, 0, 2'd0);
        repeat (4) step(1, 4'b0, 4'b0, 4'b0, 8'hBC, 1, 0, 0, 2'd0);
        step(1, 4'b0, 4'b0, 4'b0, 8'h7C, 1, 1, 0, 2'd0);
        step(1, 4'b0, 4'b0, 4'b0, 8'h7C, 1, 1, 0, 2'd0);

        // Lane 2 three-byte packet
        data2 = 8'h11;
        step(1, 4'b0100, 4'b0, 4'b0, 8'h7C, 1, 1, 1, 2'd2);
        step(1, 4'b0100, 4'b0, 4'b0100, 8'h11, 1, 1, 1, 2'd2);
        data2 = 8'h22;
        step(1, 4'b0100, 4'b0, 4'b0100, 8'h22, 1, 1, 1, 2'd2);
        data2 = 8'h33;
        step(1, 4'b0100, 4'b0100, 4'b0100, 8'h33, 1, 1, 1, 2'd2);
        data2 = lane_b[2];
        step(1, 4'b0, 4'b0, 4'b0, 8'h7C, 1, 1, 0, 2'd0);

        // All lanes requesting: rr_ptr=3 so order is 3,0,1,2,3, four bytes each.
        // Lane 1's fourth byte also carries last (single burst end).
        begin
            logic [1:0] order [5];
            order[0] = 2'd3; order[1] = 2'd0; order[2] = 2'd1;
            order[3] = 2'd2; order[4] = 2'd3;
            for (int n = 0; n < 5; n++) begin
                logic [1:0] g;
                g = order[n];
                step(1, 4'b1111, 4'b0, 4'b0, 8'h7C, 1, 1, 1, g);
                for (int k = 0; k < 4; k++) begin
                    step(1, 4'b1111, (k == 3 && g == 2'd1) ? 4'b0010 : 4'b0000,
                         4'b0001 << g, lane_b[g], 1, 1, 1, g);
                end
            end
        end

        // Lane 1 single-byte burst, then lanes 0 and 2: lane 2 first, lane 0 next
        step(1, 4'b0010, 4'b0010, 4'b0, 8'h7C, 1, 1, 1, 2'd1);
        step(1, 4'b0010, 4'b0010, 4'b0010, 8'hB1, 1, 1, 1, 2'd1);
        step(1, 4'b0101, 4'b0101, 4'b0, 8'h7C, 1, 1, 1, 2'd2);
        step(1, 4'b0101, 4'b0101, 4'b0100, 8'hC2, 1, 1, 1, 2'd2);
        step(1, 4'b0101, 4'b0101, 4'b0, 8'h7C, 1, 1, 1, 2'd0);
        step(1, 4'b0101, 4'b0101, 4'b0001, 8'hA0, 1, 1, 1, 2'd0);

        // Lane 3 drops req after two bytes; last while not acked is ignored
        step(1, 4'b1000, 4'b1000, 4'b0, 8'h7C, 1, 1, 1, 2'd3);
        step(1, 4'b1000, 4'b0, 4'b1000, 8'hD3, 1, 1, 1, 2'd3);
        step(1, 4'b1000, 4'b0, 4'b1000, 8'hD3, 1, 1, 1, 2'd3);
        step(1, 4'b0000, 4'b0, 4'b0, 8'h7C, 1, 1, 1, 2'd3);
        step(1, 4'b1001, 4'b0, 4'b0, 8'h7C, 1, 1, 1, 2'd0);
        step(1, 4'b1001, 4'b0, 4'b0001, 8'hA0, 1, 1, 1, 2'd0);

        // enable low mid-burst, then retrain; rr_ptr held at 0
        step(0, 4'b1001, 4'b0, 4'b0, 8'h00, 0, 0, 0, 2'd0);
        step(1, 4'b1111, 4'b0, 4'b0, 8'h00, 0, 0, 0, 2'd0);
        repeat (4) step(1, 4'b1111, 4'b0, 4'b0, 8'hBC, 1, 0, 0, 2'd0);
        step(1, 4'b1111, 4'b0, 4'b0, 8'h7C, 1, 1, 1, 2'd0);
        step(1, 4'b1111, 4'b0, 4'b0001, 8'hA0, 1, 1, 1, 2'd0);
        step(1, 4'b0000, 4'b0, 4'b0, 8'h7C, 1, 1, 1, 2'd0);

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk4f);
        #3;
        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
